// File: rtl/nvram_xfer_controller_if.sv
// nvram_xfer_controller_if: bridge-side save/load commands, status and packed word streams.
interface nvram_xfer_controller_if #(
    parameter int WORD_W = 32
);
    logic              save_req;
    logic              load_req;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] sv_word;
    logic              sv_valid;
    logic              sv_ready;
    logic [WORD_W-1:0] ld_word;
    logic              ld_valid;
    logic              ld_ready;

    modport slave (
        input  save_req, load_req, sv_ready, ld_word, ld_valid,
        output busy, done, sv_word, sv_valid, ld_ready
    );

    modport master (
        output save_req, load_req, sv_ready, ld_word, ld_valid,
        input  busy, done, sv_word, sv_valid, ld_ready
    );
endinterface

// File: rtl/nvram_xfer_controller.sv
// nvram_xfer_controller: shares the CPU NVRAM port with bridge save/load transfers,
// moving the whole RAM as packed words while CPU writes are locked out.
module nvram_xfer_controller #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int PACK   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_data,
    output logic [DATA_W-1:0]     cpu_q,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_data,
    input  logic [DATA_W-1:0]     ram_q,
    nvram_xfer_controller_if.slave br
);
    localparam int K_W    = $clog2(PACK);
    localparam int W_W    = ADDR_W - K_W;
    localparam int WORD_W = PACK * DATA_W;

    typedef enum logic [2:0] {
        IDLE, SAVE_RD, SAVE_LAST, SAVE_OUT, LOAD_WAIT, LOAD_WR, DONE
    } state_t;

    state_t            state, state_nx;
    logic [W_W-1:0]    w;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    cap_k;
    logic              cap_v;
    logic [WORD_W-1:0] sv_word_r;
    logic [WORD_W-1:0] ld_buf;
    logic              w_last;
    logic              k_last;

    assign w_last = &w;
    assign k_last = &k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // ram_q lags the issued address by one cycle, so captures trail the address by a cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w         <= '0;
            k         <= '0;
            cap_v     <= 1'b0;
            cap_k     <= '0;
            sv_word_r <= '0;
            ld_buf    <= '0;
        end else begin
            cap_v <= state == SAVE_RD;
            cap_k <= k;
            if (cap_v) sv_word_r[cap_k*DATA_W +: DATA_W] <= ram_q;
            if (state == SAVE_RD || state == LOAD_WR) k <= k + 1'b1;
            if (!w_last && ((state == SAVE_OUT && br.sv_ready) || (state == LOAD_WR && k_last)))
                w <= w + 1'b1;
            if (state == LOAD_WAIT && br.ld_valid) ld_buf <= br.ld_word;
            if (state == DONE) begin
                w <= '0;
                k <= '0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = br.save_req ? SAVE_RD : br.load_req ? LOAD_WAIT : IDLE;
            SAVE_RD:   state_nx = k_last ? SAVE_LAST : SAVE_RD;
            SAVE_LAST: state_nx = SAVE_OUT;
            SAVE_OUT:  state_nx = !br.sv_ready ? SAVE_OUT : w_last ? DONE : SAVE_RD;
            LOAD_WAIT: state_nx = br.ld_valid ? LOAD_WR : LOAD_WAIT;
            LOAD_WR:   state_nx = !k_last ? LOAD_WR : w_last ? DONE : LOAD_WAIT;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        br.busy     = state != IDLE;
        br.done     = state == DONE;
        br.sv_valid = state == SAVE_OUT;
        br.ld_ready = state == LOAD_WAIT;
        br.sv_word  = sv_word_r;
        cpu_q       = ram_q;
        ram_address = state == IDLE ? cpu_addr  : {w, k};
        ram_write   = state == IDLE ? cpu_write : state == LOAD_WR;
        ram_data    = state == IDLE ? cpu_data  : ld_buf[k*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_nvram_xfer_controller.sv
// tb_nvram_xfer_controller: directed save/load/CPU scenarios with a queue-based scoreboard
// checking every accepted save word and every CPU read.
module tb_nvram_xfer_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_addr;
    logic       cpu_write;
    logic [3:0] cpu_data;
    logic [3:0] cpu_q;
    logic [7:0] ram_address;
    logic       ram_write;
    logic [3:0] ram_data;
    logic [3:0] ram_q;
    logic [3:0] mem [256];

    nvram_xfer_controller_if bif();

    nvram_xfer_controller dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_data(cpu_data), .cpu_q(cpu_q),
        .ram_address(ram_address), .ram_write(ram_write), .ram_data(ram_data), .ram_q(ram_q),
        .br(bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    int          tests = 0, fails = 0;
    int          sv_hs = 0, ld_hs = 0, done_cnt = 0;
    int          hs0, lat;
    logic [31:0] sv_exp [$];
    logic [3:0]  rd_exp [$];
    logic        rd_strobe = 1'b0, rd_d = 1'b0;
    logic [31:0] held;
    logic [7:0]  addr_h;
    logic        stable, ok, no_ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_d <= rd_strobe;

    always @(negedge clk) begin
        if (rd_d) begin
            if (rd_exp.size() == 0) begin
                tests++; fails++;
                $display("FAIL cpu_q_extra: got %h with no expected read", cpu_q);
            end else check("cpu_q", cpu_q, rd_exp.pop_front());
        end
        if (bif.sv_valid && bif.sv_ready) begin
            sv_hs++;
            if (sv_exp.size() == 0) begin
                tests++; fails++;
                $display("FAIL sv_word_extra: got %h with no expected word", bif.sv_word);
            end else check("sv_word", bif.sv_word, sv_exp.pop_front());
        end
        if (bif.ld_valid && bif.ld_ready) ld_hs++;
        if (bif.done) done_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [3:0] d);
        cpu_addr = a; cpu_data = d; cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] a, input logic [3:0] e);
        cpu_addr = a; rd_strobe = 1'b1;
        rd_exp.push_back(e);
        step();
        rd_strobe = 1'b0;
    endtask

    task automatic push_pattern_b();
        for (int w = 0; w < 32; w++) sv_exp.push_back({8{w[3:0]}});
    endtask

    task automatic pulse_save();
        bif.save_req = 1'b1;
        step();
        bif.save_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int t = 0; t < 3000 && !bif.done; t++) step();
        check({name, "_done_seen"}, bif.done, 1);
        step();
        check({name, "_busy_after"}, bif.busy, 0);
    endtask

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_write = 1'b0; cpu_data = '0;
        bif.save_req = 1'b0; bif.load_req = 1'b0; bif.sv_ready = 1'b0;
        bif.ld_word = '0; bif.ld_valid = 1'b0;
        step(2);
        check("rst_busy", bif.busy, 0);
        check("rst_done", bif.done, 0);
        check("rst_sv_valid", bif.sv_valid, 0);
        check("rst_ld_ready", bif.ld_ready, 0);
        check("rst_sv_word", bif.sv_word, 0);
        reset = 1'b0;
        step();

        // CPU passthrough
        cpu_wr(8'h12, 4'hA);
        cpu_rd(8'h12, 4'hA);
        check("t1_busy", bif.busy, 0);

        // save of a known pattern
        for (int n = 0; n < 256; n++) cpu_wr(n[7:0], n[3:0]);
        for (int w = 0; w < 32; w++) sv_exp.push_back(w[0] ? 32'hFEDCBA98 : 32'h76543210);
        hs0 = sv_hs;
        bif.sv_ready = 1'b1;
        pulse_save();
        check("t2_busy", bif.busy, 1);
        lat = 0;
        while (!bif.sv_valid && lat < 50) begin step(); lat++; end
        check("t2_sv_latency", lat, 9);
        wait_done("t2");
        check("t2_words", sv_hs - hs0, 32);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_queue_empty", sv_exp.size(), 0);

        // load with ld_valid gaps
        hs0 = ld_hs;
        bif.sv_ready = 1'b0;
        bif.load_req = 1'b1;
        step();
        bif.load_req = 1'b0;
        for (int w = 0; w < 32; w++) begin
            repeat (w % 4) step();
            bif.ld_word = {8{w[3:0]}};
            bif.ld_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 40 && !ok; t++) begin ok = bif.ld_ready; step(); end
            bif.ld_valid = 1'b0;
            check("t3_ld_accept", ok, 1);
        end
        wait_done("t3");
        check("t3_ld_count", ld_hs - hs0, 32);
        check("t3_done_pulses", done_cnt, 2);
        cpu_rd(8'h25, 4'h4);
        cpu_rd(8'hF8, 4'hF);
        cpu_rd(8'h9C, 4'h3);
        cpu_rd(8'h07, 4'h0);
        step(2);

        // save with a 5-cycle stall on word 3
        push_pattern_b();
        hs0 = sv_hs;
        bif.sv_ready = 1'b1;
        pulse_save();
        for (int t = 0; t < 400 && (sv_hs - hs0) < 3; t++) step();
        bif.sv_ready = 1'b0;
        for (int t = 0; t < 50 && !bif.sv_valid; t++) step();
        check("t4_valid_stalled", bif.sv_valid, 1);
        held = bif.sv_word; addr_h = ram_address; stable = 1'b1;
        repeat (5) begin
            step();
            stable &= bif.sv_valid && bif.sv_word == held && ram_address == addr_h;
        end
        check("t4_stall_stable", stable, 1);
        check("t4_held_word", held, 32'h33333333);
        bif.sv_ready = 1'b1;
        wait_done("t4");
        check("t4_words", sv_hs - hs0, 32);
        check("t4_done_pulses", done_cnt, 3);
        check("t4_queue_empty", sv_exp.size(), 0);

        // simultaneous requests and a dropped CPU write
        push_pattern_b();
        hs0 = sv_hs;
        bif.save_req = 1'b1; bif.load_req = 1'b1;
        step();
        bif.save_req = 1'b0; bif.load_req = 1'b0;
        no_ld = !bif.ld_ready;
        step(3);
        cpu_wr(8'h00, 4'h5);
        for (int t = 0; t < 3000 && !bif.done; t++) begin no_ld &= !bif.ld_ready; step(); end
        check("t5_ld_ready_low", no_ld, 1);
        wait_done("t5");
        check("t5_words", sv_hs - hs0, 32);
        check("t5_done_pulses", done_cnt, 4);
        cpu_rd(8'h00, 4'h0);
        step(2);

        // reset in the middle of word 10
        push_pattern_b();
        hs0 = sv_hs;
        pulse_save();
        for (int t = 0; t < 1000 && (sv_hs - hs0) < 10; t++) step();
        bif.sv_ready = 1'b0;
        for (int t = 0; t < 50 && !bif.sv_valid; t++) step();
        check("t6_word10", bif.sv_word, 32'hAAAAAAAA);
        #2 reset = 1'b1;
        #1;
        check("t6_async_busy", bif.busy, 0);
        check("t6_async_sv_valid", bif.sv_valid, 0);
        check("t6_async_sv_word", bif.sv_word, 0);
        sv_exp.delete();
        step();
        reset = 1'b0;
        step();
        cpu_rd(8'h53, 4'hA);
        cpu_rd(8'h25, 4'h4);
        step(2);
        push_pattern_b();
        hs0 = sv_hs;
        bif.sv_ready = 1'b1;
        pulse_save();
        wait_done("t6");
        check("t6_words", sv_hs - hs0, 32);
        check("t6_done_pulses", done_cnt, 5);
        check("t6_queue_empty", sv_exp.size(), 0);
        check("t6_rd_queue_empty", rd_exp.size(), 0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
